// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one synchronous FIFO write port.
// Each grant accepts up to BURST words, stalls on fifo_full, and is followed by one idle arbitration cycle.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [WIDTH-1:0]   fifo_data,
    output logic [7:0]         burst_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;
    logic             w_accept;
    logic             w_release;
    logic [WIDTH-1:0] w_lane [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane[g] = din[g*WIDTH +: WIDTH];
    end

    // Scan from farthest to nearest offset so the nearest requester after r_last wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_last + 2'(4 - i);
            if (req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        ack         = '0;
        fifo_wr     = 1'b0;
        fifo_data   = '0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                fifo_data      = w_lane[r_owner];
                w_accept       = req[r_owner] & ~fifo_full;
                fifo_wr        = w_accept;
                ack[r_owner]   = w_accept;
                w_release      = ~req[r_owner] | (w_accept & (r_cnt == LAST_BEAT));
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign burst_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (BURST=4 and BURST=1) share stimulus and are
// compared every cycle against a grant/word-count reference model, plus directed scenario checks.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req;
    logic        full;
    logic [7:0]  word [4];
    logic [31:0] din;
    assign din = {word[3], word[2], word[1], word[0]};

    logic [3:0] gnt0, ack0, gnt1, ack1;
    logic       wr0, wr1;
    logic [7:0] data0, data1, cnt0, cnt1;

    fifo_wr_arbiter #(.WIDTH(8), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt0), .ack(ack0),
        .fifo_full(full), .fifo_wr(wr0), .fifo_data(data0), .burst_cnt(cnt0)
    );

    fifo_wr_arbiter #(.WIDTH(8), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt1), .ack(ack1),
        .fifo_full(full), .fifo_wr(wr1), .fifo_data(data1), .burst_cnt(cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Model per instance: owner lane (-1 = nobody), words taken in this grant, last served lane.
    int m_own  [2];
    int m_cnt  [2];
    int m_last [2];

    logic [3:0] s_gnt0, s_gnt1;
    logic       s_wr0, s_wr1;
    logic [7:0] s_cnt0;

    function automatic int burst_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic bit m_acc(input int d);
        return (m_own[d] >= 0) && req[m_own[d]] && !full;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]  = -1;
            m_cnt[d]  = 0;
            m_last[d] = 3;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit acc;
            bit found;
            if (m_own[d] < 0) begin
                if (req != 4'b0) begin
                    found = 1'b0;
                    for (int s = 1; s <= 4; s++) begin
                        if (!found && req[(m_last[d] + s) % 4]) begin
                            m_own[d] = (m_last[d] + s) % 4;
                            found    = 1'b1;
                        end
                    end
                    m_cnt[d] = 0;
                end
            end else begin
                acc = m_acc(d);
                if (!req[m_own[d]] || (acc && m_cnt[d] == burst_of(d) - 1)) begin
                    m_last[d] = m_own[d];
                    m_own[d]  = -1;
                    m_cnt[d]  = 0;
                end else if (acc) begin
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [3:0] eg, ea;
            logic       ew;
            logic [7:0] ed;
            eg = (m_own[d] < 0) ? 4'b0 : (4'b0001 << m_own[d]);
            ew = m_acc(d);
            ea = ew ? eg : 4'b0;
            ed = (m_own[d] < 0) ? 8'h00 : word[m_own[d]];
            chk($sformatf("gnt%0d", d),  32'(d == 0 ? gnt0 : gnt1),   32'(eg));
            chk($sformatf("ack%0d", d),  32'(d == 0 ? ack0 : ack1),   32'(ea));
            chk($sformatf("wr%0d", d),   32'(d == 0 ? wr0 : wr1),     32'(ew));
            chk($sformatf("data%0d", d), 32'(d == 0 ? data0 : data1), 32'(ed));
            chk($sformatf("cnt%0d", d),  32'(d == 0 ? cnt0 : cnt1),   32'(m_cnt[d]));
        end
    endtask

    // One clock: check at negedge, advance model at posedge, then requesters advance acked words.
    task automatic cycle();
        logic [3:0] acked;
        @(negedge clk);
        check_outputs();
        s_gnt0 = gnt0;
        s_gnt1 = gnt1;
        s_wr0  = wr0;
        s_wr1  = wr1;
        s_cnt0 = cnt0;
        acked  = m_acc(0) ? (4'b0001 << m_own[0]) : 4'b0;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acked[i]) word[i] = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        full  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int wcount;

    initial begin
        for (int i = 0; i < 4; i++) word[i] = 8'($urandom);

        // Single requester, FIFO never full
        do_reset();
        req = 4'b0001;
        for (int c = 0; c <= 6; c++) begin
            cycle();
            chk($sformatf("t1_gnt_c%0d", c), 32'(s_gnt0),
                ((c >= 1 && c <= 4) || c == 6) ? 32'h1 : 32'h0);
            chk($sformatf("t1_wr_c%0d", c), 32'(s_wr0),
                ((c >= 1 && c <= 4) || c == 6) ? 32'h1 : 32'h0);
        end

        // All four requesting: rotation 0,1,2,3,0 with 4 words each
        do_reset();
        req = 4'b1111;
        wcount = 0;
        for (int c = 0; c <= 21; c++) begin
            cycle();
            if (c <= 20 && s_wr0) wcount++;
            if (c == 1)  chk("t2_gnt_first",  32'(s_gnt0), 32'h1);
            if (c == 6)  chk("t2_gnt_second", 32'(s_gnt0), 32'h2);
            if (c == 11) chk("t2_gnt_third",  32'(s_gnt0), 32'h4);
            if (c == 16) chk("t2_gnt_fourth", 32'(s_gnt0), 32'h8);
            if (c == 21) chk("t2_gnt_wrap",   32'(s_gnt0), 32'h1);
        end
        chk("t2_words", 32'(wcount), 32'd16);

        // Lane 2 with a 3-cycle full stall after its 2nd word
        do_reset();
        req = 4'b0100;
        wcount = 0;
        for (int c = 0; c <= 8; c++) begin
            full = (c >= 3 && c <= 5);
            cycle();
            if (s_wr0) wcount++;
            if (c >= 3 && c <= 5) begin
                chk($sformatf("t3_stall_wr_c%0d", c),  32'(s_wr0),  32'h0);
                chk($sformatf("t3_stall_cnt_c%0d", c), 32'(s_cnt0), 32'd2);
            end
        end
        chk("t3_words", 32'(wcount), 32'd4);
        chk("t3_released", 32'(s_gnt0), 32'h0);

        // Lane 1 drops after one word while lane 3 waits; lane 1 then loses to lane 3
        do_reset();
        req = 4'b1010;
        for (int c = 0; c <= 4; c++) begin
            if (c == 2) req = 4'b1000;
            if (c == 3) req = 4'b1010;
            cycle();
            if (c == 1) chk("t4_lane1_write", 32'(s_wr0), 32'h1);
            if (c == 2) chk("t4_drop_nowr",   32'(s_wr0), 32'h0);
            if (c == 4) chk("t4_next_lane3",  32'(s_gnt0), 32'h8);
        end

        // Asynchronous reset mid-burst
        do_reset();
        req = 4'b0001;
        for (int c = 0; c <= 2; c++) cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_gnt_async", 32'(gnt0), 32'h0);
        chk("t5_wr_async",  32'(wr0),  32'h0);
        chk("t5_cnt_async", 32'(cnt0), 32'h0);
        check_outputs();
        rst_n = 1'b1;
        req   = 4'b0110;
        for (int c = 0; c <= 1; c++) begin
            cycle();
            if (c == 1) chk("t5_first_after_reset", 32'(s_gnt0), 32'h2);
        end

        // BURST=1 alternation on the second instance
        do_reset();
        req = 4'b0101;
        for (int c = 0; c <= 5; c++) begin
            cycle();
            chk($sformatf("t6_gnt1_c%0d", c), 32'(s_gnt1),
                (c == 1 || c == 5) ? 32'h1 : (c == 3) ? 32'h4 : 32'h0);
            chk($sformatf("t6_wr1_c%0d", c), 32'(s_wr1), (c % 2 == 1) ? 32'h1 : 32'h0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]  = 1'b1;
                    word[i] = 8'($urandom);
                end
            end
            full = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
